// File: rtl/mdu_unit.sv
`default_nettype none
// ============================================================================
// mdu_unit : multi-cycle multiply/divide unit owning the HI/LO registers
// Revision : 1.0
// ============================================================================
module mdu_unit #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mdOp,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             req,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] hi_n, lo_n;
  logic [WIDTH-1:0] pend_hi, pend_hi_n, pend_lo, pend_lo_n;
  logic             pend_wr, pend_wr_n;
  logic             accept;

  logic signed [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0]        prod_u;
  logic                      div_zero, div_ovf;
  logic [WIDTH-1:0]          dvs_s, dvs_u;
  logic signed [WIDTH-1:0]   quot_s, rem_s;
  logic [WIDTH-1:0]          quot_u, rem_u;

  assign prod_s = $signed({{WIDTH{rs_val[WIDTH-1]}}, rs_val}) *
                  $signed({{WIDTH{rt_val[WIDTH-1]}}, rt_val});
  assign prod_u = {{WIDTH{1'b0}}, rs_val} * {{WIDTH{1'b0}}, rt_val};

  // Divisor forced to 1 on zero (result discarded) and on MIN/-1, where
  // dividing by 1 yields exactly the required quotient MIN and remainder 0.
  assign div_zero = (rt_val == '0);
  assign div_ovf  = (rs_val == MIN_VAL) && (rt_val == '1);
  assign dvs_s    = (div_zero || div_ovf) ? ONE : rt_val;
  assign dvs_u    = div_zero ? ONE : rt_val;
  assign quot_s   = $signed(rs_val) / $signed(dvs_s);
  assign rem_s    = $signed(rs_val) % $signed(dvs_s);
  assign quot_u   = rs_val / dvs_u;
  assign rem_u    = rs_val % dvs_u;

  assign accept = start && !req && (state == IDLE);
  assign busy   = (state == RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      hi      <= hi_n;
      lo      <= lo_n;
      pend_hi <= pend_hi_n;
      pend_lo <= pend_lo_n;
      pend_wr <= pend_wr_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    hi_n      = hi;
    lo_n      = lo;
    pend_hi_n = pend_hi;
    pend_lo_n = pend_lo;
    pend_wr_n = pend_wr;
    case (state)
      IDLE: begin
        if (accept) begin
          case (mdOp)
            3'd0: begin
              pend_hi_n = prod_s[2*WIDTH-1:WIDTH];
              pend_lo_n = prod_s[WIDTH-1:0];
              pend_wr_n = 1'b1;
              cnt_n     = MULT_CNT;
              state_n   = RUN;
            end
            3'd1: begin
              pend_hi_n = prod_u[2*WIDTH-1:WIDTH];
              pend_lo_n = prod_u[WIDTH-1:0];
              pend_wr_n = 1'b1;
              cnt_n     = MULT_CNT;
              state_n   = RUN;
            end
            3'd2: begin
              pend_hi_n = rem_s;
              pend_lo_n = quot_s;
              pend_wr_n = !div_zero;
              cnt_n     = DIV_CNT;
              state_n   = RUN;
            end
            3'd3: begin
              pend_hi_n = rem_u;
              pend_lo_n = quot_u;
              pend_wr_n = !div_zero;
              cnt_n     = DIV_CNT;
              state_n   = RUN;
            end
            3'd4:    hi_n = rs_val;
            3'd5:    lo_n = rs_val;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_n = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          state_n = IDLE;
          if (pend_wr) begin
            hi_n = pend_hi;
            lo_n = pend_lo;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mdu_unit.sv
`default_nettype none
// ============================================================================
// tb_mdu_unit : vector table, corner sequences and randomized model checks
// Revision : 1.0
// ============================================================================
module tb_mdu_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  mdOp = 3'd0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        req = 1'b0;
  logic        busy;
  logic [31:0] hi, lo;

  mdu_unit #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .mdOp(mdOp),
    .rs_val(rs_val), .rt_val(rt_val), .req(req),
    .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        rq;
    int          lat;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  vec_t        vecs[12];
  int          compared = 0;
  int          mismatched = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: straight 64-bit arithmetic on the architectural rules.
  task automatic ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic rq, output int lat, output logic [31:0] eh,
                           output logic [31:0] el);
    longint      sa, sb, q, r;
    logic [63:0] p;
    eh = m_hi; el = m_lo; lat = 0;
    if (!rq) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
        3'd0: begin p = 64'(sa * sb); eh = p[63:32]; el = p[31:0]; lat = 5; end
        3'd1: begin p = {32'b0, a} * {32'b0, b}; eh = p[63:32]; el = p[31:0]; lat = 5; end
        3'd2: begin
          lat = 10;
          if (b != 0) begin q = sa / sb; r = sa % sb; el = q[31:0]; eh = r[31:0]; end
        end
        3'd3: begin
          lat = 10;
          if (b != 0) begin el = a / b; eh = a % b; end
        end
        3'd4: eh = a;
        3'd5: el = a;
        default: ;
      endcase
    end
  endtask

  // Called at a negedge; returns at the first negedge where busy reads 0.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic rq, input int lat, input logic [31:0] eh,
                        input logic [31:0] el, input string name);
    int n;
    start = 1'b1; mdOp = op; rs_val = a; rt_val = b; req = rq;
    @(negedge clk);
    start = 1'b0; req = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      check({name, " hold_hi"}, 64'(hi), 64'(m_hi));
      check({name, " hold_lo"}, 64'(lo), 64'(m_lo));
      n++;
      @(negedge clk);
    end
    check({name, " busy_cycles"}, 64'(n), 64'(lat));
    check({name, " hi"}, 64'(hi), 64'(eh));
    check({name, " lo"}, 64'(lo), 64'(el));
    m_hi = eh; m_lo = el;
  endtask

  initial begin
    int          lat, n;
    logic [31:0] eh, el, a, b;
    logic [2:0]  op;
    logic        rq;

    vecs[0]  = '{3'd0, 32'hFFFFFFFD, 32'd5,        1'b0, 5,  32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'd2,        1'b0, 5,  32'h00000001, 32'hFFFFFFFE};
    vecs[2]  = '{3'd2, 32'd7,        32'd2,        1'b0, 10, 32'd1,        32'd3};
    vecs[3]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        1'b0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 10, 32'd0,        32'h80000000};
    vecs[5]  = '{3'd4, 32'h1234,     32'd0,        1'b0, 0,  32'h1234,     32'h80000000};
    vecs[6]  = '{3'd5, 32'h5678,     32'd0,        1'b0, 0,  32'h1234,     32'h5678};
    vecs[7]  = '{3'd3, 32'd7,        32'd0,        1'b0, 10, 32'h1234,     32'h5678};
    vecs[8]  = '{3'd0, 32'd9,        32'd9,        1'b1, 0,  32'h1234,     32'h5678};
    vecs[9]  = '{3'd5, 32'hAAAA,     32'd0,        1'b1, 0,  32'h1234,     32'h5678};
    vecs[10] = '{3'd5, 32'hAAAA,     32'd0,        1'b0, 0,  32'h1234,     32'hAAAA};
    vecs[11] = '{3'd6, 32'hBEEF,     32'hBEEF,     1'b0, 0,  32'h1234,     32'hAAAA};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset busy", 64'(busy), 64'(0));
    check("reset hi", 64'(hi), 64'(0));
    check("reset lo", 64'(lo), 64'(0));

    // Each vector issues the moment busy reads 0, so 1->2 is back-to-back.
    for (int i = 0; i < 12; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rq, vecs[i].lat,
             vecs[i].eh, vecs[i].el, $sformatf("vec%0d", i));

    // Asynchronous reset between edges, three cycles into a divide.
    start = 1'b1; mdOp = 3'd2; rs_val = 32'd100; rt_val = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst busy", 64'(busy), 64'(0));
    check("async_rst hi", 64'(hi), 64'(0));
    check("async_rst lo", 64'(lo), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    @(negedge clk);

    // mult 2*3 with a stray mtlo pulsed while busy; the stray must be ignored.
    start = 1'b1; mdOp = 3'd0; rs_val = 32'd2; rt_val = 32'd3;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      if (n == 1) begin start = 1'b1; mdOp = 3'd5; rs_val = 32'hDEAD; end
      else start = 1'b0;
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_start busy_cycles", 64'(n), 64'(5));
    check("busy_start hi", 64'(hi), 64'(0));
    check("busy_start lo", 64'(lo), 64'(6));
    m_hi = 32'd0; m_lo = 32'd6;

    // Randomized operations against the reference model.
    for (int i = 0; i < 80; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 9) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
      rq = ($urandom_range(0, 7) == 0);
      ref_model(op, a, b, rq, lat, eh, el);
      run_op(op, a, b, rq, lat, eh, el, $sformatf("rand%0d op%0d", i, op));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Parametrised multi-cycle multiply/divide unit for the E stage of the pipelined MIPS core.
- It sits beside the single-cycle ALU and owns the HI/LO architectural registers.
- It models a fixed multiply or divide latency with a busy counter, so the hazard unit can stall any later mult/div/mfhi/mflo/mthi/mtlo.
- A pending exception/interrupt request cancels the instruction in E, so the victim cannot corrupt HI/LO.

Parameters:
- WIDTH, 32: operand and HI/LO width in bits.
- MULT_LAT, 5: busy cycles for mult/multu (>=1).
- DIV_LAT, 10: busy cycles for div/divu (>=1).
- CNT_W, 4: counter width; must satisfy 2^CNT_W > max(MULT_LAT, DIV_LAT).

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-high; clears all state.
- start, input, 1: instruction in E is an MDU op; sampled at posedge.
- mdOp, input, 3: operation select. 0 = mult, 1 = multu, 2 = div, 3 = divu, 4 = mthi, 5 = mtlo. 6 and 7 are no-ops.
- rs_val, input, WIDTH: operand A (dividend, multiplicand, or mthi/mtlo source).
- rt_val, input, WIDTH: operand B (divisor or multiplier).
- req, input, 1: exception/interrupt pending this cycle. Any start seen while req=1 is discarded.
- busy, output, 1: registered; high while an operation is in flight.
- hi, output, WIDTH: architectural HI register.
- lo, output, WIDTH: architectural LO register.

Behaviour:
Reset:
- reset=1 at any time, including mid-operation, immediately forces busy=0, hi=0, lo=0, counter=0 and pending results=0.
- The in-flight operation is lost.

Acceptance:
- A start is accepted at a posedge when start=1, req=0 and busy=0.
- start while busy=1 is ignored. The hazard unit guarantees it never happens; the bench checks that HI/LO are unaffected.

mthi/mtlo:
- On an accepted start, hi (or lo) takes rs_val at that same posedge.
- busy stays 0.

mult/div:
- On an accepted start, the unit computes the full result and loads it into internal pending_hi/pending_lo.
- At the same edge it loads the counter with LAT and sets busy=1.

Counting and commit:
- Each later posedge with busy=1 decrements the counter.
- The edge that takes the counter from 1 to 0 clears busy and copies pending_hi/pending_lo into hi/lo.
- Net effect: busy is high for exactly LAT cycles, and the new hi/lo are visible in the first cycle busy is low.
- Back-to-back operation: a new start is accepted in the cycle busy first reads 0.

States (2-state FSM):
- IDLE: busy=0. Goes to RUN on an accepted mult/div; otherwise stays in IDLE.
- RUN: busy=1. Goes to IDLE with commit when the counter reaches 0.
- req has no effect in RUN. Cancellation applies only to the accepting cycle, because a committed mult/div is already architecturally retired past M.

Arithmetic:
- mult: signed WIDTH x WIDTH product, 2*WIDTH bits; hi = upper half, lo = lower half.
- multu: same as mult, but unsigned.
- div: lo = quotient truncated toward zero; hi = remainder, which takes the sign of the dividend.
- Signed overflow (MIN / -1): lo = MIN, hi = 0.
- divu: unsigned quotient and remainder.
- Divide by zero, div or divu: RUN still lasts DIV_LAT cycles, but hi/lo are left unchanged on commit.

Simultaneous events:
- reset overrides everything.
- req together with start: nothing changes, busy stays 0.
- mdOp values 6 and 7 with start: no state change.

Test Plan:
- Reset then mult rs=0xFFFFFFFD (-3), rt=5 -> busy high for exactly 5 cycles; next cycle hi=0xFFFFFFFF, lo=0xFFFFFFF1; hi/lo hold old values while busy.
- multu rs=0xFFFFFFFF, rt=2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE. A follow-on div 7/2 issued the cycle busy drops is accepted; 10 cycles later lo=3, hi=1.
- div rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. div rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
- First mthi 0x1234 and mtlo 0x5678; then divu 7/0 -> busy for 10 cycles, after which hi=0x1234 and lo=0x5678 are unchanged.
- start mult with req=1 -> busy stays 0 and hi/lo unchanged. mtlo 0xAAAA with req=1 -> lo unchanged. Same mtlo with req=0 -> lo=0xAAAA on that edge.
- Assert reset asynchronously (between edges) 3 cycles into a div -> busy, hi and lo read 0 immediately. After release, mult 2*3 -> lo=6 after 5 cycles.
